// File: rtl/mw_sub_pkg.sv
// Shared definitions for the multi-word serial subtractor: limb width,
// operation state encoding and the limb-counter width helper.
package mw_sub_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter must be able to hold the value MAX_LIMBS itself.
    function automatic int count_width(input int max_limbs);
        return $clog2(max_limbs + 1);
    endfunction

endpackage

// File: rtl/bla_sub_16bit.sv
// Combinational 16-bit borrow-lookahead subtractor: d = a - b - bin.
// Implemented as a two-level lookahead adder on a + ~b + ~bin, where the
// final carry-out is the complement of the borrow-out.
module bla_sub_16bit import mw_sub_pkg::*; (
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              bin,
    output logic [LIMB_W-1:0] d,
    output logic              bout
);

    logic [LIMB_W-1:0] g;
    logic [LIMB_W-1:0] p;
    logic [LIMB_W-1:0] ci;
    logic [3:0]        gg;
    logic [3:0]        gp;
    logic [4:0]        gc;
    logic              carry;

    // Bit and 4-bit group generate/propagate, group carries, then per-bit
    // carries derived from each group's carry-in.
    always_comb begin
        g     = a & ~b;
        p     = a ^ ~b;
        gg    = '0;
        gp    = '0;
        gc    = '0;
        ci    = '0;
        carry = ~bin;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        for (int k = 0; k < 4; k++) begin
            gc[k] = carry;
            carry = gg[k] | (gp[k] & carry);
        end
        gc[4] = carry;
        for (int k = 0; k < 4; k++) begin
            ci[4*k]   = gc[k];
            ci[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            ci[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                      | (p[4*k+1] & p[4*k] & gc[k]);
            ci[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                      | (p[4*k+2] & p[4*k+1] & g[4*k])
                      | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        d    = p ^ ci;
        bout = ~gc[4];
    end

endmodule

// File: rtl/mw_sub_16bit.sv
// Multi-word serial subtractor: streams A - B as 16-bit limbs, LS limb
// first, chaining the borrow between beats. One-deep output register with
// valid/ready on both sides. Define MW_SUB_SIGNED_OVF_EN to enable the
// signed-overflow flag on the final limb; otherwise out_ovf is tied low.
module mw_sub_16bit import mw_sub_pkg::*; #(
    parameter int MAX_LIMBS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LIMB_W-1:0] in_a,
    input  logic [LIMB_W-1:0] in_b,
    input  logic              in_bin,
    input  logic              in_first,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LIMB_W-1:0] out_d,
    output logic              out_bout,
    output logic              out_last,
    output logic              out_zero,
    output logic              out_err,
    output logic              out_ovf
);

    localparam int CW = count_width(MAX_LIMBS);

    state_t            state_q;
    state_t            state_d;
    logic              borrow_q;
    logic              zacc_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_next;
    logic              accept;
    logic              first_beat;
    logic              bin_sel;
    logic              frame_err;
    logic              trunc;
    logic              last_beat;
    logic              zacc_next;
    logic [LIMB_W-1:0] diff;
    logic              diff_bout;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_bout = borrow_q;
    assign out_zero = zacc_q;

    bla_sub_16bit u_sub (
        .a    (in_a),
        .b    (in_b),
        .bin  (bin_sel),
        .d    (diff),
        .bout (diff_bout)
    );

    // Classify the presented beat: first/restart, borrow source, framing
    // errors, truncation at MAX_LIMBS and the running zero flag.
    always_comb begin
        first_beat = (state_q == IDLE) || in_first;
        bin_sel    = first_beat ? in_bin : borrow_q;
        frame_err  = (state_q == IDLE) ? !in_first : in_first;
        count_next = first_beat ? CW'(1) : count_q + CW'(1);
        trunc      = (count_next == CW'(MAX_LIMBS)) && !in_last;
        last_beat  = in_last || trunc;
        zacc_next  = (first_beat ? 1'b1 : zacc_q) && (diff == '0);
    end

    // Next state: close the operation on the final beat, open it otherwise.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = last_beat ? IDLE : BUSY;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operation registers and output register; stall holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_d     <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            borrow_q  <= 1'b0;
            zacc_q    <= 1'b0;
            count_q   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_d     <= diff;
            out_last  <= last_beat;
            out_err   <= frame_err || trunc;
            borrow_q  <= diff_bout;
            zacc_q    <= zacc_next;
            count_q   <= count_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MW_SUB_SIGNED_OVF_EN
    logic ovf_next;

    assign ovf_next = last_beat & (in_a[LIMB_W-1] ^ in_b[LIMB_W-1])
                    & (in_a[LIMB_W-1] ^ diff[LIMB_W-1]);

    // Signed overflow flag, registered alongside the result limb.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ovf <= 1'b0;
        end else if (accept) begin
            out_ovf <= ovf_next;
        end
    end
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mw_sub_16bit.sv
// Self-checking bench for mw_sub_16bit: directed scenarios plus random
// traffic, compared against an arithmetic reference model and scoreboard.
module tb_mw_sub_16bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_bin;
    logic        in_first;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_d;
    logic        out_bout;
    logic        out_last;
    logic        out_zero;
    logic        out_err;
    logic        out_ovf;

    typedef struct packed {
        logic [15:0] d;
        logic        bout;
        logic        last;
        logic        zero;
        logic        err;
        logic        ovf;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    m_open;
    bit    m_borrow;
    int    m_count;
    bit    m_zero;

    always #5 clk = ~clk;

    mw_sub_16bit #(.MAX_LIMBS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_bin    (in_bin),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_bout  (out_bout),
        .out_last  (out_last),
        .out_zero  (out_zero),
        .out_err   (out_err),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one accepted limb, computed with plain integer math.
    task automatic modelBeat(input logic [15:0] a, input logic [15:0] b,
                             input logic bin_in, input logic first_in,
                             input logic last_in, output beat_t e);
        bit first;
        bit bsel;
        bit trunc;
        int t;
        int ts;
        first  = !m_open || first_in;
        e      = '0;
        e.err  = m_open ? first_in : !first_in;
        bsel   = first ? bin_in : m_borrow;
        t      = int'(a) - int'(b) - int'(bsel);
        e.d    = t[15:0];
        e.bout = (t < 0);
        m_count = first ? 1 : m_count + 1;
        trunc  = (m_count == 8) && !last_in;
        e.last = last_in || trunc;
        e.err  = e.err || trunc;
        e.zero = (first ? 1'b1 : m_zero) && (e.d == 16'h0);
        ts     = int'($signed(a)) - int'($signed(b)) - int'(bsel);
`ifdef MW_SUB_SIGNED_OVF_EN
        e.ovf  = e.last && ((ts < -32768) || (ts > 32767));
`else
        e.ovf  = 1'b0;
        if (ts == 0) e.ovf = 1'b0;
`endif
        m_open   = !e.last;
        m_borrow = e.bout;
        m_zero   = e.zero;
    endtask

    task automatic checkOutput();
        chk("in_ready", in_ready, (exp_q.size() == 0) || out_ready);
        chk("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("out_d", out_d, exp_q[0].d);
            chk("out_bout", out_bout, exp_q[0].bout);
            chk("out_last", out_last, exp_q[0].last);
            chk("out_zero", out_zero, exp_q[0].zero);
            chk("out_err", out_err, exp_q[0].err);
            chk("out_ovf", out_ovf, exp_q[0].ovf);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic bin, input logic first, input logic last,
                                 input logic ordy);
        bit    acc;
        bit    pop;
        beat_t e;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_bin    = bin;
        in_first  = first;
        in_last   = last;
        out_ready = ordy;
        #1;
        checkOutput();
        acc = v && ((exp_q.size() == 0) || ordy);
        pop = (exp_q.size() != 0) && ordy;
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            modelBeat(a, b, bin, first, last, e);
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_open   = 1'b0;
        m_borrow = 1'b0;
        m_count  = 0;
        m_zero   = 1'b0;
    endtask

    task automatic sendOp(input logic [127:0] A, input logic [127:0] B, input int n,
                          input logic bin);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, A[16*i +: 16], B[16*i +: 16], bin, i == 0, i == n - 1, 1'b1);
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [127:0] ra;
        logic [127:0] rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_bin    = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        doReset();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_d", out_d, 0);
        chk("rst_out_bout", out_bout, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_zero", out_zero, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_ovf", out_ovf, 0);

        $display("[TB] single limb");
        applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("single_d", out_d, 16'hFFFE);
        chk("single_bout", out_bout, 1);
        chk("single_last", out_last, 1);
        chk("single_err", out_err, 0);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] three limbs");
        sendOp(128'h0001_0000_0000, 128'h0000_0000_0001, 3, 1'b0);

        $display("[TB] equal operands");
        ra = {$urandom, $urandom, $urandom, $urandom};
        sendOp(ra, ra, 4, 1'b0);
        sendOp(128'h8000_1234, 128'h0001_1234, 2, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 16'h1000, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h1000, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] framing");
        applyStimulus(1'b1, 16'h0000, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0010, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0020, 16'h0020, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 16'h0007, 16'h0007, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 16'(i), 16'(i + 1), 1'b0, i == 0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0009, 16'h0003, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            ra[15:0] = 16'($urandom);
            rb[15:0] = ($urandom_range(0, 3) == 0) ? ra[15:0] : 16'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, ra[15:0], rb[15:0],
                          1'($urandom), $urandom_range(0, 7) == 0,
                          $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
        end

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0003, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0003, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        doReset();
        applyStimulus(1'b1, 16'h0005, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
